// File: rtl/am_fm_pkg.sv
// Shared widths, mode encoding and output scaling shift for the AM/FM modulator.
// No logic; constants only.
// No flow control.
package am_fm_pkg;

    localparam int WIN_DEF    = 16;
    localparam int WPHASE_DEF = 24;
    localparam int WLUT_DEF   = 10;
    localparam int WOUT_DEF   = 14;

    localparam logic MODE_AM = 1'b0;
    localparam logic MODE_FM = 1'b1;

    // Right shift that maps the Q2.(2(WIN-1)) envelope*carrier product onto WOUT bits.
    function automatic int out_shift(input int win, input int wout);
        return 2 * (win - 1) - (wout - 1);
    endfunction

endpackage

// File: rtl/sine_lut_rom.sv
// Full-wave sine ROM, round((2^(WIN-1)-1)*sin(2*pi*k/2^WLUT)), built at elaboration.
// Latency 1 cycle (registered read).
// No backpressure; reads every cycle.
module sine_lut_rom #(
    parameter int WLUT = 10,
    parameter int WIN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WLUT-1:0]       addr,
    output logic signed [WIN-1:0] rd_dat
);

    localparam int DEPTH = 2 ** WLUT;

    function automatic int sine_word(input int k);
        real x;
        x = (2.0 ** (WIN - 1) - 1.0) * $sin(2.0 * 3.14159265358979323846 * k / DEPTH);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    logic signed [WIN-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int WORD = sine_word(k);
        assign rom[k] = WIN'(WORD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_dat <= '0;
        else     rd_dat <= rom[addr];
    end

endmodule

// File: rtl/am_fm_mod_core.sv
// AM/FM modulator: phase accumulator + sine LUT + envelope multiply, config applied on phase wrap.
// Latency 5 cycles val_in -> val_out, one sample per cycle.
// No backpressure; val_out is val_in delayed by 5.
module am_fm_mod_core
    import am_fm_pkg::*;
#(
    parameter int WIN    = WIN_DEF,
    parameter int WPHASE = WPHASE_DEF,
    parameter int WLUT   = WLUT_DEF,
    parameter int WOUT   = WOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [WIN-1:0]         i_data,
    input  logic                   val_in,
    input  logic                   cfg_load,
    input  logic                   c_fm_am,
    input  logic [WPHASE-1:0]      frec_por,
    input  logic [WIN-1:0]         im_am,
    input  logic [WIN-1:0]         im_fm,
    output logic signed [WOUT-1:0] o_data,
    output logic                   val_out,
    output logic                   cfg_pending,
    output logic                   sat
);

    localparam int S  = out_shift(WIN, WOUT);
    localparam int WP = 2 * WIN + 1;
    localparam int WE = WIN + 2;
    localparam int WC = WE + WIN;

    localparam logic signed [WE-1:0] ENV_ONE = WE'(1) << (WIN - 1);
    localparam logic signed [WC-1:0] RND     = WC'(1) << (S - 1);
    localparam logic signed [WC-1:0] Y_MAX   = (WC'(1) << (WOUT - 1)) - WC'(1);
    localparam logic signed [WC-1:0] Y_MIN   = -(WC'(1) << (WOUT - 1));

    typedef struct packed {
        logic              mode;
        logic [WPHASE-1:0] frec;
        logic [WIN-1:0]    im_am;
        logic [WIN-1:0]    im_fm;
    } cfg_t;

    cfg_t cfg_shadow, cfg_active, cfg_eff;

    logic                   s1_vld, s1_run;
    logic signed [WP-1:0]   s1_pam, s1_pfm;
    logic signed [WP-1:0]   mul_am, mul_fm, dev_full;
    logic [WPHASE-1:0]      acc, inc;
    logic [WPHASE:0]        acc_sum;
    logic                   wrap, apply;
    logic signed [WE-1:0]   env_am;

    logic                   s2_vld, s2_run;
    logic [WLUT-1:0]        s2_addr;
    logic signed [WE-1:0]   s2_env;
    logic                   s3_vld, s3_run;
    logic signed [WE-1:0]   s3_env;
    logic signed [WIN-1:0]  lut_dat;
    logic                   s4_vld, s4_run;
    logic signed [WC-1:0]   s4_prod, y_full;
    logic signed [WOUT-1:0] y_sat;
    logic                   sat_hit;

    // Sample entering S1 while its predecessor applies a new config must already see that config.
    assign cfg_eff = apply ? cfg_shadow : cfg_active;
    assign mul_am  = WP'($signed(i_data)) * WP'($signed({1'b0, cfg_eff.im_am}));
    assign mul_fm  = WP'($signed(i_data)) * WP'($signed({1'b0, cfg_eff.im_fm}));

    assign dev_full = s1_pfm >>> (WIN - 1);
    assign inc      = cfg_active.frec + ((cfg_active.mode == MODE_FM) ? WPHASE'(dev_full) : '0);
    assign acc_sum  = {1'b0, acc} + {1'b0, inc};
    assign wrap     = s1_vld & s1_run & acc_sum[WPHASE];
    assign apply    = cfg_pending & (~s1_run | wrap);
    assign env_am   = ENV_ONE + WE'(s1_pam >>> (WIN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_shadow  <= '0;
            cfg_active  <= '0;
            cfg_pending <= 1'b0;
        end else begin
            if (cfg_load) cfg_shadow <= {c_fm_am, frec_por, im_am, im_fm};
            if (apply)    cfg_active <= cfg_shadow;
            cfg_pending <= cfg_load | (cfg_pending & ~apply);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_run  <= 1'b0;
            s1_pam  <= '0;
            s1_pfm  <= '0;
            acc     <= '0;
            s2_vld  <= 1'b0;
            s2_run  <= 1'b0;
            s2_addr <= '0;
            s2_env  <= '0;
            s3_vld  <= 1'b0;
            s3_run  <= 1'b0;
            s3_env  <= '0;
            s4_vld  <= 1'b0;
            s4_run  <= 1'b0;
            s4_prod <= '0;
        end else begin
            s1_vld  <= val_in;
            s1_run  <= run;
            s1_pam  <= mul_am;
            s1_pfm  <= mul_fm;
            if (!s1_run)     acc <= '0;
            else if (s1_vld) acc <= acc_sum[WPHASE-1:0];
            s2_vld  <= s1_vld;
            s2_run  <= s1_run;
            s2_addr <= acc[WPHASE-1 -: WLUT];
            s2_env  <= (cfg_active.mode == MODE_FM) ? ENV_ONE : env_am;
            s3_vld  <= s2_vld;
            s3_run  <= s2_run;
            s3_env  <= s2_env;
            s4_vld  <= s3_vld;
            s4_run  <= s3_run;
            s4_prod <= WC'(s3_env) * WC'(lut_dat);
        end
    end

    sine_lut_rom #(.WLUT(WLUT), .WIN(WIN)) u_lut (
        .clk    (clk),
        .rst    (rst),
        .addr   (s2_addr),
        .rd_dat (lut_dat)
    );

    assign y_full = (s4_prod + RND) >>> S;

    always_comb begin
        y_sat   = WOUT'(y_full);
        sat_hit = 1'b0;
        if (y_full > Y_MAX) begin
            y_sat   = WOUT'(Y_MAX);
            sat_hit = 1'b1;
        end else if (y_full < Y_MIN) begin
            y_sat   = WOUT'(Y_MIN);
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data  <= '0;
            val_out <= 1'b0;
            sat     <= 1'b0;
        end else begin
            val_out <= s4_vld;
            if (s4_vld) o_data <= s4_run ? y_sat : '0;
            sat <= ~cfg_load & (sat | (s4_vld & s4_run & sat_hit));
        end
    end

endmodule

// File: tb/tb_am_fm_mod_core.sv
// Randomized + directed bench for am_fm_mod_core with a sample-level reference model and scoreboard.
module tb_am_fm_mod_core;

    localparam longint P = 64'd1 << 24;

    logic               clk = 1'b0;
    logic               rst, run, val_in, cfg_load, c_fm_am;
    logic [15:0]        i_data, im_am, im_fm;
    logic [23:0]        frec_por;
    logic signed [13:0] o_data;
    logic               val_out, cfg_pending, sat;

    am_fm_mod_core #(.WIN(16), .WPHASE(24), .WLUT(10), .WOUT(14)) dut (
        .clk(clk), .rst(rst), .run(run), .i_data(i_data), .val_in(val_in),
        .cfg_load(cfg_load), .c_fm_am(c_fm_am), .frec_por(frec_por),
        .im_am(im_am), .im_fm(im_fm), .o_data(o_data), .val_out(val_out),
        .cfg_pending(cfg_pending), .sat(sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sine_tab [1024];
    int peak;
    int out_log [$];

    typedef struct { longint y; int t; } exp_t;
    exp_t exp_q [$];

    typedef struct { bit fm; longint frec; longint ia; longint ifm; } mcfg_t;
    mcfg_t  m_act, m_sh;
    bit     m_pend, p_vld, p_run;
    longint m_acc, p_m;

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint fdiv(longint a, longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Reference model: each sample takes the config active when its phase is accumulated,
    // its carrier phase is the accumulator value before its own increment.
    always @(posedge clk) begin
        longint inc, env, y;
        bit wrap, apply;
        cyc++;
        if (rst) begin
            m_act = '{0, 0, 0, 0};
            m_sh  = '{0, 0, 0, 0};
            m_pend = 0; m_acc = 0; p_vld = 0; p_run = 0; p_m = 0;
            exp_q.delete();
        end else begin
            wrap = 0;
            inc = m_act.frec;
            if (m_act.fm) inc = m_act.frec + fdiv(p_m * m_act.ifm, 32768);
            inc = ((inc % P) + P) % P;
            if (p_vld) begin
                env = m_act.fm ? 32768 : 32768 + fdiv(p_m * m_act.ia, 32768);
                y = fdiv(env * sine_tab[m_acc / 16384] + 65536, 131072);
                if (y > 8191) y = 8191;
                if (y < -8192) y = -8192;
                if (!p_run) y = 0;
                exp_q.push_back('{y, cyc + 3});
            end
            if (!p_run) m_acc = 0;
            else if (p_vld) begin
                m_acc += inc;
                if (m_acc >= P) begin wrap = 1; m_acc -= P; end
            end
            apply = m_pend && (!p_run || wrap);
            if (apply) m_act = m_sh;
            if (cfg_load) m_sh = '{c_fm_am, frec_por, im_am, im_fm};
            m_pend = cfg_load || (m_pend && !apply);
            p_vld = val_in;
            p_run = run;
            p_m   = longint'($signed(i_data));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && val_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_val_out", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("o_data", o_data, e.y);
                check("latency", cyc, e.t);
                out_log.push_back(o_data);
                if (o_data > peak) peak = o_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(bit fm, int unsigned frec, int unsigned a, int unsigned f);
        cfg_load = 1; c_fm_am = fm; frec_por = frec[23:0]; im_am = a[15:0]; im_fm = f[15:0];
        tick();
        cfg_load = 0;
    endtask

    task automatic stream(int n, int mval, bit rnd);
        for (int i = 0; i < n; i++) begin
            val_in = 1;
            i_data = rnd ? 16'($urandom) : mval[15:0];
            tick();
        end
        val_in = 0;
    endtask

    task automatic drain();
        repeat (8) tick();
        check("missing_val_out", exp_q.size(), 0);
    endtask

    task automatic idle_load(bit fm, int unsigned frec, int unsigned a, int unsigned f);
        run = 0;
        load_cfg(fm, frec, a, f);
        tick();
        run = 1;
        out_log.delete();
        peak = -100000;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            real x;
            x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
            sine_tab[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
        end
        rst = 1; run = 0; val_in = 0; cfg_load = 0; c_fm_am = 0;
        i_data = 0; im_am = 0; im_fm = 0; frec_por = 0; peak = -100000;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_o_data", o_data, 0);
        check("rst_val_out", val_out, 0);
        check("rst_cfg_pending", cfg_pending, 0);
        check("rst_sat", sat, 0);
        tick();

        // Pure carrier, 16-sample period, quarter-wave sample saturates.
        idle_load(0, 1 << 20, 0, 0);
        check("pending_after_idle_apply", cfg_pending, 0);
        stream(40, 0, 1);
        drain();
        check("carrier_quarter_wave", (out_log.size() > 4) ? out_log[4] : -1, 8191);
        check("carrier_peak", peak, 8191);
        check("carrier_sat", sat, 1);

        // AM index: positive m saturates, negative m halves the envelope.
        idle_load(0, 1 << 20, 32768, 0);
        check("sat_cleared_by_load", sat, 0);
        stream(32, 16384, 0);
        drain();
        check("am_pos_peak", peak, 8191);
        check("am_pos_sat", sat, 1);
        idle_load(0, 1 << 20, 32768, 0);
        stream(32, -16384, 0);
        drain();
        check("am_neg_peak", peak, 4096);
        check("am_neg_sat", sat, 0);

        // FM deviation: accumulator after 8 samples.
        idle_load(1, 1 << 20, 0, 32768);
        stream(8, 16384, 0);
        tick();
        check("fm_acc_8", dut.acc, 8 * ((1 << 20) + (1 << 14)));
        drain();

        // Config change mid-cycle, applied on wrap.
        idle_load(0, 1 << 20, 0, 0);
        stream(6, 0, 1);
        val_in = 1; i_data = 16'($urandom);
        load_cfg(0, 1 << 21, 0, 0);
        check("pending_mid_cycle", cfg_pending, 1);
        stream(5, 0, 1);
        check("pending_before_wrap", cfg_pending, 1);
        stream(30, 0, 1);
        check("pending_after_wrap", cfg_pending, 0);
        drain();

        // Gapped valid, then run=0 with valid.
        for (int i = 0; i < 30; i++) begin
            val_in = (i % 3 == 0); i_data = 16'($urandom);
            tick();
        end
        val_in = 0;
        drain();
        run = 0;
        stream(10, 0, 1);
        check("acc_held_run0", dut.acc, 0);
        drain();

        // Randomized traffic, config loads and run toggles.
        run = 1;
        for (int i = 0; i < 1500; i++) begin
            val_in = ($urandom_range(0, 3) != 0);
            i_data = 16'($urandom);
            if ($urandom_range(0, 49) == 0) run = ~run;
            cfg_load = ($urandom_range(0, 29) == 0);
            c_fm_am  = 1'($urandom);
            frec_por = 24'($urandom_range(1 << 16, 1 << 22));
            im_am    = 16'($urandom);
            im_fm    = 16'($urandom);
            tick();
        end
        cfg_load = 0; val_in = 0;
        drain();

        // Reset in the middle of a stream.
        run = 1;
        stream(10, 0, 1);
        val_in = 1;
        rst = 1;
        #1;
        check("midrst_o_data", o_data, 0);
        check("midrst_val_out", val_out, 0);
        check("midrst_cfg_pending", cfg_pending, 0);
        check("midrst_sat", sat, 0);
        exp_q.delete();
        val_in = 0;
        repeat (2) tick();
        rst = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
